blit_write_combiner: RTL and testbench

//  Next-generation blitter write combiner. Coalesces narrow pixel writes from the blit pipeline into bus-wide

---
 rtl/blit_pkg.sv | 24 ++
 rtl/blit_wc_fifo.sv | 75 +++++++
 rtl/blit_write_combiner.sv | 155 +++++++++++++++
 tb/tb_blit_write_combiner.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/blit_pkg.sv
// Shared types and helpers for the blitter write combiner.
// Default geometry, line payload type and the lane-index helper.
package blit_pkg;

  localparam int unsigned WC_ADDR_W    = 26;
  localparam int unsigned WC_BUS_BYTES = 4;
  localparam int unsigned WC_IN_BYTES  = 1;
  localparam int unsigned WC_DEPTH     = 2;
  localparam int unsigned WC_TIMEOUT   = 16;

  typedef struct packed {
    logic [WC_ADDR_W-1:0]      addr;
    logic [8*WC_BUS_BYTES-1:0] data;
    logic [WC_BUS_BYTES-1:0]   be;
  } wc_line_t;

  // Pixel slot within a bus line for a given byte address.
  function automatic int unsigned lane_of(input logic [31:0] addr,
                                          input int unsigned bus_bytes,
                                          input int unsigned in_bytes);
    return (addr % bus_bytes) / in_bytes;
  endfunction

endpackage

// File: rtl/blit_wc_fifo.sv
// First-word fall-through line FIFO with registered head, valid and level flags.
module blit_wc_fifo
  import blit_pkg::*;
#(
  parameter int unsigned DEPTH = WC_DEPTH,
  parameter type line_t = wc_line_t
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  line_t                    push_line,
  input  logic                     pop,
  output line_t                    head,
  output logic                     head_valid,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  line_t            mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr_n;
  logic [PTR_W-1:0] wr_ptr_n;
  logic [CNT_W-1:0] count_n;
  line_t            head_n;
  logic             do_push;
  logic             do_pop;

  // Next pointers and the head that will be visible after this edge.
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_n = wr_ptr + PTR_W'(do_push);
    rd_ptr_n = rd_ptr + PTR_W'(do_pop);
    count_n  = count + CNT_W'(do_push) - CNT_W'(do_pop);
    if (count_n == '0) begin
      head_n = '0;
    end else if (do_push && (rd_ptr_n == wr_ptr)) begin
      head_n = push_line;
    end else begin
      head_n = mem[rd_ptr_n];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      full       <= 1'b0;
      empty      <= 1'b1;
      head       <= '0;
      head_valid <= 1'b0;
    end else begin
      rd_ptr     <= rd_ptr_n;
      wr_ptr     <= wr_ptr_n;
      count      <= count_n;
      full       <= (count_n == CNT_W'(DEPTH));
      empty      <= (count_n == '0);
      head       <= head_n;
      head_valid <= (count_n != '0);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= push_line;
    end
  end

endmodule

// File: rtl/blit_write_combiner.sv
// Coalesces narrow pixel writes into bus-wide line writes with byte enables,
// closing lines on miss, full line, upstream idle or timeout.
module blit_write_combiner
  import blit_pkg::*;
#(
  parameter int unsigned ADDR_W    = WC_ADDR_W,
  parameter int unsigned BUS_BYTES = WC_BUS_BYTES,
  parameter int unsigned IN_BYTES  = WC_IN_BYTES,
  parameter int unsigned DEPTH     = WC_DEPTH,
  parameter int unsigned TIMEOUT   = WC_TIMEOUT
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ADDR_W-1:0]       in_addr,
  input  logic [8*IN_BYTES-1:0]   in_data,
  input  logic                    in_idle,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ADDR_W-1:0]       out_addr,
  output logic [8*BUS_BYTES-1:0]  out_data,
  output logic [BUS_BYTES-1:0]    out_byte_enable,
  output logic                    busy
);

  localparam int unsigned LANES  = BUS_BYTES / IN_BYTES;
  localparam int unsigned IN_W   = 8 * IN_BYTES;
  localparam int unsigned BUS_W  = 8 * BUS_BYTES;
  localparam int unsigned CNT_W  = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam int unsigned FCNT_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_W-1:0]    addr;
    logic [BUS_W-1:0]     data;
    logic [BUS_BYTES-1:0] be;
  } line_t;

  logic                 acc_valid, acc_valid_n;
  logic [ADDR_W-1:0]    acc_addr, acc_addr_n;
  logic [BUS_W-1:0]     acc_data, acc_data_n;
  logic [BUS_BYTES-1:0] acc_be, acc_be_n;
  logic [CNT_W-1:0]     idle_cnt, idle_cnt_n;

  logic                 fifo_full;
  logic                 fifo_empty;
  logic [FCNT_W-1:0]    fifo_count;
  logic [FCNT_W-1:0]    fifo_count_n;
  line_t                push_line;
  line_t                head;

  logic                 accept, hit, flush, push, pop;
  logic [31:0]          lane;
  logic [ADDR_W-1:0]    in_line;
  logic [BUS_W-1:0]     wr_data;
  logic [BUS_W-1:0]     wr_mask;
  logic [BUS_BYTES-1:0] wr_be;

  // in_ready depends only on the registered full flag.
  assign in_ready        = !fifo_full;
  assign out_valid       = !fifo_empty;
  assign out_addr        = head.addr;
  assign out_data        = head.data;
  assign out_byte_enable = head.be;
  assign push_line       = '{addr: acc_addr, data: acc_data, be: acc_be};
  assign in_line         = in_addr & ~ADDR_W'(BUS_BYTES - 1);
  assign lane            = lane_of(32'(in_addr), BUS_BYTES, IN_BYTES);

  // Place the incoming pixel in its lane of a bus-wide word.
  always_comb begin
    wr_data = '0;
    wr_mask = '0;
    wr_be   = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      if (lane == l) begin
        wr_data[l*IN_W +: IN_W]         = in_data;
        wr_mask[l*IN_W +: IN_W]         = '1;
        wr_be[l*IN_BYTES +: IN_BYTES]   = '1;
      end
    end
  end

  // Flush decision and next open-line state.
  always_comb begin
    accept      = in_valid && !fifo_full;
    hit         = acc_valid && (in_line == acc_addr);
    flush       = acc_valid && ((accept && !hit) || (&acc_be) || in_idle ||
                  ((TIMEOUT != 0) && (idle_cnt == CNT_W'(TIMEOUT))));
    push        = flush && !fifo_full;
    pop         = !fifo_empty && out_ready;

    acc_valid_n = acc_valid;
    acc_addr_n  = acc_addr;
    acc_data_n  = acc_data;
    acc_be_n    = acc_be;
    idle_cnt_n  = idle_cnt;

    if (acc_valid && (idle_cnt != CNT_W'(TIMEOUT))) begin
      idle_cnt_n = idle_cnt + CNT_W'(1);
    end
    if (push) begin
      acc_valid_n = 1'b0;
    end
    // A write landing in a push cycle always starts a fresh line.
    if (accept) begin
      idle_cnt_n = '0;
      if (!acc_valid_n) begin
        acc_valid_n = 1'b1;
        acc_addr_n  = in_line;
        acc_data_n  = wr_data;
        acc_be_n    = wr_be;
      end else begin
        acc_data_n  = (acc_data & ~wr_mask) | wr_data;
        acc_be_n    = acc_be | wr_be;
      end
    end

    fifo_count_n = fifo_count + FCNT_W'(push) - FCNT_W'(pop);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_valid <= 1'b0;
      acc_addr  <= '0;
      acc_data  <= '0;
      acc_be    <= '0;
      idle_cnt  <= '0;
      busy      <= 1'b0;
    end else begin
      acc_valid <= acc_valid_n;
      acc_addr  <= acc_addr_n;
      acc_data  <= acc_data_n;
      acc_be    <= acc_be_n;
      idle_cnt  <= idle_cnt_n;
      busy      <= acc_valid_n || (fifo_count_n != '0);
    end
  end

  blit_wc_fifo #(
    .DEPTH  (DEPTH),
    .line_t (line_t)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (push),
    .push_line  (push_line),
    .pop        (pop),
    .head       (head),
    .head_valid (),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count)
  );

endmodule

// File: tb/tb_blit_write_combiner.sv
// Randomized and directed bench for blit_write_combiner against a queue-based
// cycle model of the coalescing rules; a second instance covers the wide variant.
module tb_blit_write_combiner;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned TO    = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, in_idle;
  logic [25:0] in_addr;
  logic [7:0]  in_data;
  logic        out_valid, out_ready, busy;
  logic [25:0] out_addr;
  logic [31:0] out_data;
  logic [3:0]  out_byte_enable;

  logic        v_valid, v_ready, v_idle;
  logic [25:0] v_addr;
  logic [15:0] v_data;
  logic        v_out_valid, v_out_ready, v_busy;
  logic [25:0] v_out_addr;
  logic [63:0] v_out_data;
  logic [7:0]  v_out_be;

  always #5 clock = ~clock;

  blit_write_combiner dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
    .in_idle(in_idle), .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data), .out_byte_enable(out_byte_enable),
    .busy(busy)
  );

  blit_write_combiner #(.BUS_BYTES(8), .IN_BYTES(2), .TIMEOUT(0)) dut_wide (
    .clock(clock), .reset(reset),
    .in_valid(v_valid), .in_ready(v_ready), .in_addr(v_addr), .in_data(v_data),
    .in_idle(v_idle), .out_valid(v_out_valid), .out_ready(v_out_ready),
    .out_addr(v_out_addr), .out_data(v_out_data), .out_byte_enable(v_out_be),
    .busy(v_busy)
  );

  typedef struct {
    int unsigned      addr;
    longint unsigned  data;
    int unsigned      be;
  } exp_line_t;

  exp_line_t    m_q[$];
  bit           m_valid;
  int unsigned  m_line;
  byte unsigned m_bytes[4];
  bit           m_mask[4];
  int unsigned  m_idle;
  bit           m_busy;
  int unsigned  popped[$];
  int unsigned  n_cmp = 0;
  int unsigned  n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  // One clock of the combining rules, from the inputs present before the edge.
  task automatic model_step();
    int unsigned sz, a, line, lane;
    bit rdy, acc, hit, flush, push, pop, full;
    exp_line_t e;
    if (reset) begin
      m_q.delete();
      m_valid = 0;
      m_idle  = 0;
      m_busy  = 0;
      return;
    end
    sz    = m_q.size();
    rdy   = sz < DEPTH;
    acc   = in_valid && rdy;
    a     = 32'(in_addr);
    line  = a - (a % 4);
    lane  = a % 4;
    full  = m_mask[0] && m_mask[1] && m_mask[2] && m_mask[3];
    hit   = m_valid && (line == m_line);
    flush = m_valid && ((acc && !hit) || full || in_idle || (TO != 0 && m_idle == TO));
    push  = flush && rdy;
    pop   = (sz != 0) && out_ready;
    if (pop) void'(m_q.pop_front());
    if (push) begin
      e.addr = m_line;
      e.data = 0;
      e.be   = 0;
      for (int i = 0; i < 4; i++) begin
        if (m_mask[i]) begin
          e.data |= 64'(m_bytes[i]) << (8 * i);
          e.be   |= 32'(1) << i;
        end
      end
      m_q.push_back(e);
    end
    if (acc) m_idle = 0;
    else if (m_valid && m_idle < TO) m_idle++;
    if (push) m_valid = 0;
    if (acc) begin
      if (!m_valid) begin
        m_valid = 1;
        m_line  = line;
        for (int i = 0; i < 4; i++) m_mask[i] = 0;
      end
      m_bytes[lane] = in_data;
      m_mask[lane]  = 1;
    end
    m_busy = m_valid || (m_q.size() != 0);
  endtask

  // Compare registered outputs with the model, then advance one edge.
  task automatic tick();
    check("in_ready", 64'(in_ready), 64'(m_q.size() < DEPTH));
    check("out_valid", 64'(out_valid), 64'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      check("out_addr", 64'(out_addr), 64'(m_q[0].addr));
      check("out_data", 64'(out_data), m_q[0].data);
      check("out_be", 64'(out_byte_enable), 64'(m_q[0].be));
    end
    check("busy", 64'(busy), 64'(m_busy));
    if (out_valid && out_ready) popped.push_back(32'(out_addr));
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input int unsigned addr, input int unsigned data);
    int unsigned k;
    bit done;
    k = 0;
    done = 0;
    in_valid = 1;
    in_addr  = 26'(addr);
    in_data  = 8'(data);
    while (!done && k < 50) begin
      done = m_q.size() < DEPTH;
      tick();
      k++;
    end
    in_valid = 0;
    check("wr_accepted", 64'(done), 64'(1));
  endtask

  task automatic pulse_reset();
    reset    = 1;
    in_valid = 0;
    in_idle  = 0;
    tick();
    reset = 0;
    popped.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned first, seen;
    reset = 1; in_valid = 0; in_idle = 0; in_addr = '0; in_data = '0; out_ready = 0;
    v_valid = 0; v_idle = 0; v_addr = '0; v_data = '0; v_out_ready = 0;
    m_valid = 0; m_idle = 0; m_busy = 0; m_line = 0;
    for (int i = 0; i < 4; i++) begin m_mask[i] = 0; m_bytes[i] = 0; end
    repeat (2) @(posedge clock);
    #1;
    reset = 0;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_addr", 64'(out_addr), 64'(0));
    check("rst_out_data", 64'(out_data), 64'(0));
    check("rst_out_be", 64'(out_byte_enable), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));

    // Full line closes without idle
    out_ready = 0;
    wr(32'h100, 32'h11); wr(32'h101, 32'h22); wr(32'h102, 32'h33); wr(32'h103, 32'h44);
    tick();
    check("t1_valid", 64'(out_valid), 64'(1));
    check("t1_addr", 64'(out_addr), 64'h100);
    check("t1_data", 64'(out_data), 64'h44332211);
    check("t1_be", 64'(out_byte_enable), 64'hF);
    out_ready = 1; tick(); out_ready = 0;

    // Miss closes the open line, idle closes the next
    pulse_reset();
    wr(32'h100, 32'hAA); wr(32'h205, 32'hBB);
    check("t2_addr0", 64'(out_addr), 64'h100);
    check("t2_data0", 64'(out_data), 64'hAA);
    check("t2_be0", 64'(out_byte_enable), 64'h1);
    in_idle = 1; out_ready = 1; tick();
    check("t2_addr1", 64'(out_addr), 64'h204);
    check("t2_data1", 64'(out_data), 64'hBB00);
    check("t2_be1", 64'(out_byte_enable), 64'h2);
    in_idle = 0; tick(); out_ready = 0;

    // Backpressure: FIFO fills, nothing lost, order kept
    pulse_reset();
    wr(32'h000, 1); wr(32'h010, 2); wr(32'h020, 3);
    check("t3_in_ready_low", 64'(in_ready), 64'(0));
    out_ready = 1;
    wr(32'h030, 4);
    in_idle = 1; tick(); in_idle = 0;
    repeat (6) tick();
    check("t3_pop_count", 64'(popped.size()), 64'(4));
    for (int i = 0; i < 4 && i < popped.size(); i++)
      check("t3_order", 64'(popped[i]), 64'(i * 16));
    out_ready = 0;

    // Timeout flush latency
    pulse_reset();
    wr(32'h300, 5);
    first = 0;
    for (int k = 1; k <= 40 && first == 0; k++) begin
      tick();
      if (out_valid) first = k;
    end
    check("t4_latency", 64'(first), 64'(TO + 1));
    out_ready = 1; tick(); tick(); out_ready = 0;

    // Same-byte rewrite keeps newer data; reset drops a queued line
    pulse_reset();
    wr(32'h100, 32'hAA); wr(32'h100, 32'hBB);
    in_idle = 1; tick(); in_idle = 0;
    check("t5_addr", 64'(out_addr), 64'h100);
    check("t5_data", 64'(out_data), 64'hBB);
    check("t5_be", 64'(out_byte_enable), 64'h1);
    reset = 1; tick(); reset = 0;
    check("t5_rst_valid", 64'(out_valid), 64'(0));
    check("t5_rst_busy", 64'(busy), 64'(0));

    // Wide variant with timeout disabled
    check("t6_ready", 64'(v_ready), 64'(1));
    v_valid = 1; v_addr = 26'h10A; v_data = 16'hBEEF;
    tick();
    v_valid = 0;
    seen = 0;
    repeat (30) begin tick(); if (v_out_valid) seen++; end
    check("t6_no_timeout", 64'(seen), 64'(0));
    check("t6_busy", 64'(v_busy), 64'(1));
    v_idle = 1; tick(); v_idle = 0;
    check("t6_valid", 64'(v_out_valid), 64'(1));
    check("t6_addr", 64'(v_out_addr), 64'h108);
    check("t6_be", 64'(v_out_be), 64'h0C);
    check("t6_data", v_out_data, 64'h00000000BEEF0000);
    v_out_ready = 1; tick(); v_out_ready = 0;
    check("t6_drained", 64'(v_out_valid), 64'(0));

    // Randomized traffic against the model
    pulse_reset();
    repeat (2000) begin
      in_valid  = ($urandom_range(0, 99) < 60);
      in_addr   = ($urandom_range(0, 3) == 0) ? 26'($urandom) : 26'(32'h100 + $urandom_range(0, 11));
      in_data   = 8'($urandom);
      in_idle   = ($urandom_range(0, 9) == 0);
      out_ready = $urandom_range(0, 1) == 1;
      reset     = ($urandom_range(0, 199) == 0);
      tick();
    end
    reset = 0; in_valid = 0; in_idle = 1; out_ready = 1;
    repeat (5) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
